// File: rtl/seq_detect_fsm_pkg.sv
// Shared types and constants for the button-strobed "1101" sequence detector.
package seq_detect_fsm_pkg;

  // Encoding equals the length of the pattern prefix matched so far.
  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S11  = 2'd2,
    S110 = 2'd3
  } state_t;

  localparam logic [3:0] PATTERN       = 4'b1101;
  localparam logic [7:0] MATCH_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == MATCH_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/seq_detect_fsm_if.sv
// Raw button/switch inputs and detector outputs bundled for the sequence detector.
interface seq_detect_fsm_if;
  logic       btn_raw;
  logic       din_raw;
  logic       pulse_p;
  logic       result;
  logic [1:0] state_dbg;
  logic [7:0] match_cnt;

  modport master (
    output btn_raw, din_raw,
    input  pulse_p, result, state_dbg, match_cnt
  );

  modport slave (
    input  btn_raw, din_raw,
    output pulse_p, result, state_dbg, match_cnt
  );
endinterface

// File: rtl/seq_detect_fsm_btn_debounce_pulse.sv
// Two-flop synchronisers for button and data switch, button debounce and a
// single-cycle step strobe on each accepted press.
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic din_raw,
  output logic step,
  output logic din_s
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw_in;
  logic [1:0] sync_s;
  logic       btn_s;

  assign raw_in = {din_raw, btn_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic sync1_reg;
      logic sync2_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
        end
      end
      assign sync_s[gi] = sync2_reg;
    end
  endgenerate

  assign btn_s = sync_s[0];
  assign din_s = sync_s[1];

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stable_reg, stable_next;
  logic             stable_d_reg;
  logic [1:0]       fill_reg;
  logic             armed_reg;

  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    if (btn_s != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = btn_s;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // A button already held through reset must not produce a press: strobes are
  // enabled only once a real released level has come through the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      fill_reg     <= 2'b00;
      armed_reg    <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      stable_reg   <= stable_next;
      stable_d_reg <= stable_reg;
      fill_reg     <= {fill_reg[0], 1'b1};
      if (fill_reg[1] && !btn_s) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign step = stable_reg & ~stable_d_reg & armed_reg;

endmodule

// File: rtl/seq_detect_fsm.sv
// Debounced bit-strobe front end feeding a Mealy "1101" detector whose result
// is registered alongside pulse_p for the downstream LED shifter.
module seq_detect_fsm
  import seq_detect_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit OVERLAP         = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_detect_fsm_if.slave bus
);

  logic step;
  logic din_s;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_raw),
    .din_raw (bus.din_raw),
    .step    (step),
    .din_s   (din_s)
  );

  state_t     state_reg, state_next;
  logic       match;
  logic       pulse_reg;
  logic       result_reg;
  logic [7:0] match_cnt_reg;

  always_comb begin
    state_next = state_reg;
    match      = 1'b0;
    if (step) begin
      case (state_reg)
        S0:   state_next = (din_s == PATTERN[3]) ? S1   : S0;
        S1:   state_next = (din_s == PATTERN[2]) ? S11  : S0;
        S11:  state_next = (din_s == PATTERN[1]) ? S110 : S11;
        S110: begin
          if (din_s == PATTERN[0]) begin
            match      = 1'b1;
            state_next = OVERLAP ? S1 : S0;
          end else begin
            state_next = S0;
          end
        end
        default: state_next = S0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S0;
      pulse_reg     <= 1'b0;
      result_reg    <= 1'b0;
      match_cnt_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      pulse_reg <= step;
      if (step) begin
        result_reg <= match;
      end
      if (match) begin
        match_cnt_reg <= sat_inc(match_cnt_reg);
      end
    end
  end

  assign bus.pulse_p   = pulse_reg;
  assign bus.result    = result_reg;
  assign bus.state_dbg = state_reg;
  assign bus.match_cnt = match_cnt_reg;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: overlapping and non-overlapping instances share one
// button/switch stimulus and are checked against a bit-history reference model.
module tb_seq_detect_fsm;

  localparam int DC    = 4;
  localparam int CNT_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b0;
  logic din   = 1'b0;

  always #5 clk = ~clk;

  seq_detect_fsm_if bus_ov ();
  seq_detect_fsm_if bus_no ();

  assign bus_ov.btn_raw = btn;
  assign bus_ov.din_raw = din;
  assign bus_no.btn_raw = btn;
  assign bus_no.din_raw = din;

  seq_detect_fsm #(.DEBOUNCE_CYCLES(DC), .CNT_W(CNT_W), .OVERLAP(1'b1)) dut_ov (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ov)
  );

  seq_detect_fsm #(.DEBOUNCE_CYCLES(DC), .CNT_W(CNT_W), .OVERLAP(1'b0)) dut_no (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_no)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  int pulses_ov = 0;
  int pulses_no = 0;
  always @(posedge clk) begin
    if (bus_ov.pulse_p === 1'b1) pulses_ov <= pulses_ov + 1;
    if (bus_no.pulse_p === 1'b1) pulses_no <= pulses_no + 1;
  end

  // Reference model: index 0 = overlapping, 1 = non-overlapping.
  // Keeps the consumed bits since reset (or since the last match when
  // non-overlapping); state is the longest suffix that is a prefix of 1101.
  logic [31:0] m_hist [2];
  int          m_len  [2];
  int          m_cnt  [2];
  int          m_res  [2];
  int          m_state[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_hist[m]  = '0;
      m_len[m]   = 0;
      m_cnt[m]   = 0;
      m_res[m]   = 0;
      m_state[m] = 0;
    end
  endtask

  task automatic model_bit(input int d);
    for (int m = 0; m < 2; m++) begin
      bit hit;
      m_hist[m] = {m_hist[m][30:0], d[0]};
      if (m_len[m] < 32) m_len[m]++;
      hit = (m_len[m] >= 4) && (m_hist[m][3:0] == 4'b1101);
      m_res[m] = hit ? 1 : 0;
      if (hit && m_cnt[m] < 255) m_cnt[m]++;
      if (hit && m == 1) begin
        m_hist[m] = '0;
        m_len[m]  = 0;
      end
      if (m_len[m] >= 3 && m_hist[m][2:0] == 3'b110)     m_state[m] = 3;
      else if (m_len[m] >= 2 && m_hist[m][1:0] == 2'b11) m_state[m] = 2;
      else if (m_len[m] >= 1 && m_hist[m][0])            m_state[m] = 1;
      else                                               m_state[m] = 0;
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check_value({tag, "_res_ov"},   int'(bus_ov.result),    m_res[0]);
    check_value({tag, "_state_ov"}, int'(bus_ov.state_dbg), m_state[0]);
    check_value({tag, "_cnt_ov"},   int'(bus_ov.match_cnt), m_cnt[0]);
    check_value({tag, "_res_no"},   int'(bus_no.result),    m_res[1]);
    check_value({tag, "_state_no"}, int'(bus_no.state_dbg), m_state[1]);
    check_value({tag, "_cnt_no"},   int'(bus_no.match_cnt), m_cnt[1]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) step_cycle();
    rst_n = 1'b1;
    repeat (5) step_cycle();
  endtask

  // One button press carrying bit d, optionally preceded by bounce_pairs
  // high/low toggles; the pulse must follow the final rise by DC+3 negedges.
  task automatic press(input int d, input int bounce_pairs, input int hold, input string tag);
    int  n;
    int  p_start;
    int  p0;
    bit  seen;
    din = d[0];
    repeat (4) step_cycle();
    p_start = pulses_ov;
    for (int i = 0; i < bounce_pairs; i++) begin
      btn = 1'b1;
      step_cycle();
      btn = 1'b0;
      step_cycle();
    end
    p0 = pulses_ov;
    if (bounce_pairs > 0) check_value({tag, "_bounce_quiet"}, p0 - p_start, 0);
    btn  = 1'b1;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus_ov.pulse_p === 1'b1) seen = 1'b1;
      else n++;
    end
    check_value({tag, "_latency"}, seen ? n : -1, DC + 3);
    check_value({tag, "_pulse_no"}, int'(bus_no.pulse_p), 1);
    if (seen) begin
      model_bit(d);
      check_outputs(tag);
    end
    @(negedge clk);
    check_value({tag, "_pulse_width"}, int'(bus_ov.pulse_p), 0);
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    btn = 1'b0;
    repeat (DC + 6) step_cycle();
    check_value({tag, "_one_pulse_ov"}, pulses_ov - p0, 1);
    check_value({tag, "_hold_res_ov"}, int'(bus_ov.result), m_res[0]);
    $display("press %-12s din=%0d res_ov=%0d res_no=%0d st_ov=%0d st_no=%0d cnt_ov=%0d cnt_no=%0d",
             tag, d, bus_ov.result, bus_no.result, bus_ov.state_dbg, bus_no.state_dbg,
             bus_ov.match_cnt, bus_no.match_cnt);
  endtask

  initial begin
    int p0;
    int bits4[4];
    int bits7[7];
    bits4 = '{1, 1, 0, 1};
    bits7 = '{1, 1, 0, 1, 1, 0, 1};

    model_reset();
    repeat (3) step_cycle();
    rst_n = 1'b1;
    repeat (5) step_cycle();
    check_value("reset_pulse", int'(bus_ov.pulse_p),   0);
    check_value("reset_res",   int'(bus_ov.result),    0);
    check_value("reset_state", int'(bus_ov.state_dbg), 0);
    check_value("reset_cnt",   int'(bus_no.match_cnt), 0);

    // Clean press held 100 cycles: one pulse, none on release.
    press(1, 0, 100, "clean");

    do_reset();
    foreach (bits4[i]) press(bits4[i], 0, 1, "s1101");

    // Reset asserted mid-cycle while a press is being debounced.
    @(posedge clk);
    #1;
    btn = 1'b1;
    repeat (3) step_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_value("arst_pulse_ov", int'(bus_ov.pulse_p),   0);
    check_value("arst_res_ov",   int'(bus_ov.result),    0);
    check_value("arst_state_ov", int'(bus_ov.state_dbg), 0);
    check_value("arst_cnt_ov",   int'(bus_ov.match_cnt), 0);
    check_value("arst_res_no",   int'(bus_no.result),    0);
    check_value("arst_cnt_no",   int'(bus_no.match_cnt), 0);
    model_reset();
    repeat (3) step_cycle();
    rst_n = 1'b1;
    p0 = pulses_ov;
    repeat (20) step_cycle();
    check_value("held_through_reset", pulses_ov - p0, 0);
    btn = 1'b0;
    repeat (DC + 6) step_cycle();
    press(1, 0, 1, "after_rst");

    do_reset();
    foreach (bits7[i]) press(bits7[i], 0, 1, "overlap");

    do_reset();
    press(0, 6, 10, "bounce");
    p0 = pulses_ov;
    @(posedge clk);
    #1;
    btn = 1'b1;
    repeat (3) step_cycle();
    btn = 1'b0;
    repeat (15) step_cycle();
    check_value("glitch_quiet", pulses_ov - p0, 0);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      press(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), "rand");
    end
    check_value("rand_pulse_pairs", pulses_no, pulses_ov);

    do_reset();
    for (int r = 0; r < 256; r++) begin
      foreach (bits4[i]) press(bits4[i], 0, 0, "sat");
    end
    check_value("sat_cnt_no", int'(bus_no.match_cnt), 255);
    check_value("sat_cnt_ov", int'(bus_ov.match_cnt), 255);

    press(1, 0, 0, "midseq");
    press(1, 0, 0, "midseq");
    press(0, 0, 0, "midseq");
    do_reset();
    check_value("midrst_state_ov", int'(bus_ov.state_dbg), 0);
    check_value("midrst_state_no", int'(bus_no.state_dbg), 0);
    press(1, 0, 0, "post_midrst");
    check_value("post_midrst_state", int'(bus_ov.state_dbg), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
- Upstream producer for the 8-bit LED result shifter.
- Takes a raw push-button (bit strobe) and a raw slide switch (data bit).
- Debounces the button and emits one single-cycle pulse_p per press.
- Runs a Mealy "1101" sequence detector on each sampled bit and presents result in the same cycle as pulse_p, so the downstream shifter captures both together.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive cycles a changed button level must persist before it is accepted (10 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
CNT_W, 20, debounce counter width.
OVERLAP, 1, 1 = overlapping detection (after a match go to S1), 0 = non-overlapping (after a match go to S0).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
btn_raw  in  1  raw asynchronous bit-strobe button, active-high.
din_raw  in  1  raw asynchronous data switch.
pulse_p  out  1  one-cycle strobe, one per accepted button press.
result  out  1  detector output for the bit just consumed; valid when pulse_p=1, held until the next pulse_p.
state_dbg  out  2  current FSM state encoding.
match_cnt  out  8  number of detections since reset; saturates at 255.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pulse_p=0, result=0, state_dbg=S0, match_cnt=0.
  - Sync flops, debounce counter, stable level and its delayed copy all cleared to 0.
- Synchronisation: btn_raw and din_raw each pass through 2 flops (btn_s, din_s).
- Debounce:
  - If btn_s != stable, counter increments each cycle; otherwise the counter is cleared.
  - On a cycle with counter == DEBOUNCE_CYCLES-1 and btn_s != stable, stable <= btn_s and the counter clears.
  - Any return of btn_s to the stable value before then clears the counter.
- Step strobe: step = stable & ~stable_d (combinational; stable_d is stable delayed 1 cycle). Exactly one step per accepted 0->1 transition; release produces none.
- Latency: with edge 0 defined as the first edge at which sync flop 1 captures 1, and btn_raw held high thereafter, pulse_p is high for exactly the cycle following edge DEBOUNCE_CYCLES+2.
- Data sampling: din_s is sampled at the step cycle. din_raw must be stable for at least 3 cycles before the step.
- FSM (2-bit, advances only on step; otherwise holds):
  - S0: d=1 -> S1; d=0 -> S0.
  - S1 ("1"): d=1 -> S11; d=0 -> S0.
  - S11 ("11"): d=1 -> S11; d=0 -> S110.
  - S110 ("110"): d=1 -> match, next state S1 if OVERLAP else S0; d=0 -> S0.
- Outputs on step:
  - result <= match, registered on the same edge as pulse_p <= 1. Next cycle pulse_p <= 0; result holds.
  - match_cnt increments on match; holds at 255 once reached.
- Simultaneous events:
  - Button and switch changing together: din is synchronised independently; no ordering guarantee. Debounce latency (≥ DEBOUNCE_CYCLES) normally covers it.
  - Reset during the debounce count discards the pending press.
  - Reset mid-sequence returns the FSM to S0; the partial prefix is lost.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - State encodings S0=2'd0, S1=2'd1, S11=2'd2, S110=2'd3.
  - Pattern constant 4'b1101.
  - MATCH_CNT_MAX=8'd255.
- One sub-module, btn_debounce_pulse: sync flops, debounce counter, stable register and step generation; parameters DEBOUNCE_CYCLES and CNT_W.
- The FSM, output registers and match counter live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3 unless noted):
1. Reset: assert rst_n=0 mid-run with btn_raw=1 -> pulse_p=0, result=0, state_dbg=0, match_cnt=0 immediately; no pulse after release until btn_raw goes 0 then 1 again.
2. Clean press timing: btn_raw rises and stays high, din_raw=1 -> pulse_p high exactly in the cycle after edge 6; held 100 cycles -> one pulse only; release -> no pulse.
3. Stream 1,1,0,1 -> result on successive pulses 0,0,0,1; state_dbg 1,2,3,1; match_cnt=1.
4. Overlap: stream 1,1,0,1,1,0,1 with OVERLAP=1 -> results 0,0,0,1,0,0,1, match_cnt=2. Same stream with OVERLAP=0 -> 0,0,0,1,0,0,0, match_cnt=1.
5. Bounce: btn_raw toggling every cycle for 12 cycles then high for 10 -> exactly one pulse_p. A 3-cycle high glitch -> no pulse.
6. Saturation and mid-sequence reset:
   - 256 repetitions of 1,1,0,1 (OVERLAP=0) -> match_cnt stays 255.
   - After 1,1,0, pulse rst_n -> state_dbg=0; next bit 1 -> result=0, state_dbg=1.
